// File: rtl/stack_calc.sv
// stack_calc: parametrised operand-stack calculator with a sticky error flag.
// Define STACK_CALC_DIV_EN to enable div/mod (opcodes 7/8) on an iterative divider; otherwise they are illegal.
module stack_calc #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in,
  input  logic [3:0]                 op,
  input  logic                       apply,
  output logic                       ready,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       valid
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    OP_PUSH = 4'd0,
    OP_POP  = 4'd1,
    OP_INC  = 4'd2,
    OP_DEC  = 4'd3,
    OP_ADD  = 4'd4,
    OP_MUL  = 4'd5,
    OP_SUB  = 4'd6,
    OP_DIV  = 4'd7,
    OP_MOD  = 4'd8,
    OP_DUP  = 4'd9,
    OP_SWAP = 4'd10,
    OP_CLR  = 4'd11
  } op_t;

  logic [WIDTH-1:0] r_stk [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic             r_valid;

  logic [IW-1:0]    w_top, w_sec, w_nxt;
  logic [WIDTH-1:0] w_a, w_b;
  logic             w_ge1, w_ge2, w_full, w_acc;
  logic             w_err, w_we0, w_we1, w_div_start;
  logic [IW-1:0]    w_idx0, w_idx1;
  logic [WIDTH-1:0] w_dat0, w_dat1;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_top  = IW'(r_cnt - CW'(1));
  assign w_sec  = IW'(r_cnt - CW'(2));
  assign w_nxt  = IW'(r_cnt);
  assign w_b    = r_stk[w_top];
  assign w_a    = r_stk[w_sec];
  assign w_ge1  = (r_cnt != '0);
  assign w_ge2  = (r_cnt >= CW'(2));
  assign w_full = (r_cnt == CW'(DEPTH));
  assign w_acc  = apply && ready && r_valid;

`ifdef STACK_CALC_DIV_EN
  localparam int BW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs, w_rem_nxt, w_quo_nxt;
  logic [BW-1:0]    r_bit;
  logic             r_is_mod, w_div_last;
  logic [WIDTH:0]   w_trial, w_diff;

  assign ready      = (r_state == S_IDLE);
  assign w_div_last = (r_state == S_DIV) && (r_bit == BW'(WIDTH-1));

  // Restoring step: r_quo starts as the dividend and shifts quotient bits in at the LSB.
  always_comb begin
    w_trial = {r_rem, r_quo[WIDTH-1]};
    w_diff  = w_trial - {1'b0, r_dvs};
    if (w_diff[WIDTH]) begin
      w_rem_nxt = w_trial[WIDTH-1:0];
      w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
    end else begin
      w_rem_nxt = w_diff[WIDTH-1:0];
      w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_div_start) w_state_nxt = S_DIV;
      S_DIV:   if (w_div_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_div_start) begin
      r_rem    <= '0;
      r_quo    <= w_a;
      r_dvs    <= w_b;
      r_bit    <= '0;
      r_is_mod <= (op == OP_MOD);
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_bit <= r_bit + BW'(1);
    end
  end
`else
  assign ready = 1'b1;
`endif

  always_comb begin
    w_err       = 1'b0;
    w_we0       = 1'b0;
    w_we1       = 1'b0;
    w_idx0      = w_top;
    w_idx1      = w_sec;
    w_dat0      = w_b;
    w_dat1      = w_a;
    w_cnt_nxt   = r_cnt;
    w_div_start = 1'b0;
    if (w_acc) begin
      // Any unlisted or unknown opcode lands in default and latches the error.
      case (op)
        OP_PUSH: begin
          if (w_full) w_err = 1'b1;
          else begin
            w_we0 = 1'b1; w_idx0 = w_nxt; w_dat0 = in; w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        OP_POP: begin
          if (!w_ge1) w_err = 1'b1;
          else        w_cnt_nxt = r_cnt - CW'(1);
        end
        OP_INC: begin
          if (!w_ge1) w_err = 1'b1;
          else begin w_we0 = 1'b1; w_dat0 = w_b + WIDTH'(1); end
        end
        OP_DEC: begin
          if (!w_ge1) w_err = 1'b1;
          else begin w_we0 = 1'b1; w_dat0 = w_b - WIDTH'(1); end
        end
        OP_ADD, OP_MUL, OP_SUB: begin
          if (!w_ge2) w_err = 1'b1;
          else begin
            w_we0     = 1'b1;
            w_idx0    = w_sec;
            w_cnt_nxt = r_cnt - CW'(1);
            if (op == OP_ADD)      w_dat0 = w_a + w_b;
            else if (op == OP_MUL) w_dat0 = w_a * w_b;
            else                   w_dat0 = w_a - w_b;
          end
        end
`ifdef STACK_CALC_DIV_EN
        OP_DIV, OP_MOD: begin
          if (!w_ge2 || (w_b == '0)) w_err = 1'b1;
          else                       w_div_start = 1'b1;
        end
`endif
        OP_DUP: begin
          if (!w_ge1 || w_full) w_err = 1'b1;
          else begin
            w_we0 = 1'b1; w_idx0 = w_nxt; w_dat0 = w_b; w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        OP_SWAP: begin
          if (!w_ge2) w_err = 1'b1;
          else begin
            w_we0 = 1'b1; w_dat0 = w_a;
            w_we1 = 1'b1; w_dat1 = w_b;
          end
        end
        OP_CLR:  w_cnt_nxt = '0;
        default: w_err = 1'b1;
      endcase
    end
`ifdef STACK_CALC_DIV_EN
    if (w_div_last) begin
      w_we0     = 1'b1;
      w_idx0    = w_sec;
      w_dat0    = r_is_mod ? w_rem_nxt : w_quo_nxt;
      w_cnt_nxt = r_cnt - CW'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_valid <= 1'b1;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_err) r_valid <= 1'b0;
      if (w_we0) r_stk[w_idx0] <= w_dat0;
      if (w_we1) r_stk[w_idx1] <= w_dat1;
    end
  end

  assign head  = w_ge1 ? w_b : '0;
  assign empty = !w_ge1;
  assign full  = w_full;
  assign count = r_cnt;
  assign valid = r_valid;

endmodule

// File: tb/tb_stack_calc.sv
// Self-checking bench for stack_calc (WIDTH=8, DEPTH=4): queue-based reference model checked every cycle,
// plus directed literal expectations. Div/mod expectations follow STACK_CALC_DIV_EN.
module tb_stack_calc;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int unsigned MASK = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] t_in = '0;
  logic [3:0]       t_op = '0;
  logic             apply = 1'b0;
  logic             ready, empty, full, valid;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    count;

  int vectors = 0;
  int miscompares = 0;

  stack_calc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in(t_in), .op(t_op), .apply(apply),
    .ready(ready), .head(head), .empty(empty), .full(full),
    .count(count), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stack as a queue, top at the back.
  int unsigned m_stk[$];
  bit          m_valid = 1'b1;
  bit          m_live  = 1'b0;
  int          m_busy  = 0;
  int unsigned m_divres;

  task automatic m_exec(input int unsigned o, input int unsigned v);
    int n;
    int unsigned a, b, r;
    bit err;
    n = m_stk.size();
    err = 1'b0;
    a = 0; b = 0;
    if (n >= 1) b = m_stk[n-1];
    if (n >= 2) a = m_stk[n-2];
    case (o)
      0: if (n == DEPTH) err = 1; else m_stk.push_back(v & MASK);
      1: if (n < 1) err = 1; else void'(m_stk.pop_back());
      2: if (n < 1) err = 1; else m_stk[n-1] = (b + 1) & MASK;
      3: if (n < 1) err = 1; else m_stk[n-1] = (b - 1) & MASK;
      4, 5, 6: begin
        if (n < 2) err = 1;
        else begin
          r = (o == 4) ? a + b : (o == 5) ? a * b : a - b;
          void'(m_stk.pop_back());
          m_stk[n-2] = r & MASK;
        end
      end
`ifdef STACK_CALC_DIV_EN
      7, 8: begin
        if (n < 2 || b == 0) err = 1;
        else begin
          m_divres = (o == 7) ? a / b : a % b;
          m_busy   = WIDTH;
        end
      end
`endif
      9:  if (n < 1 || n == DEPTH) err = 1; else m_stk.push_back(b);
      10: if (n < 2) err = 1; else begin m_stk[n-1] = a; m_stk[n-2] = b; end
      11: m_stk.delete();
      default: err = 1;
    endcase
    if (err) m_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_stk.delete();
      m_valid = 1'b1;
      m_busy  = 0;
      m_live  = 1'b1;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        void'(m_stk.pop_back());
        m_stk[m_stk.size()-1] = m_divres;
      end
    end else if (apply && m_valid) begin
      m_exec(t_op, t_in);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model.head",  head,  (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 0);
      chk("model.count", count, m_stk.size());
      chk("model.empty", empty, m_stk.size() == 0);
      chk("model.full",  full,  m_stk.size() == DEPTH);
      chk("model.valid", valid, m_valid);
      chk("model.ready", ready, m_busy == 0);
    end
  end

  task automatic do_reset();
    rst = 1'b1; apply = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] o, input logic [WIDTH-1:0] v);
    t_op = o; t_in = v; apply = 1'b1;
    @(posedge clk); #1;
    apply = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk(name, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    chk("rst.head", head, 0);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.count", count, 0);
    chk("rst.valid", valid, 1);
    chk("rst.ready", ready, 1);

    do_op(0, 8'h00); chk("push0.head", head, 8'h00);
    do_op(3, 8'h00); chk("dec.head", head, 8'hFF);
    do_op(2, 8'h00); chk("inc.head", head, 8'h00);
    do_op(1, 8'h00); chk("pop.empty", empty, 1); chk("pop.valid", valid, 1);

    do_reset();
    do_op(0, 8'd5); do_op(0, 8'd3); do_op(4, 8'd0); chk("add.head", head, 8);
    do_op(0, 8'd3); do_op(6, 8'd0); chk("sub.head", head, 5);
    do_op(0, 8'd3); do_op(5, 8'd0); chk("mul.head", head, 8'h0F);
    do_op(0, 8'd2); do_op(7, 8'd0);
`ifdef STACK_CALC_DIV_EN
    chk("div.busy", ready, 0);
    chk("div.head_busy", head, 2);
    repeat (WIDTH - 1) begin @(posedge clk); #1; end
    chk("div.still_busy", ready, 0);
    @(posedge clk); #1;
    chk("div.ready", ready, 1);
    chk("div.head", head, 7);
    do_op(0, 8'd5); do_op(8, 8'd0);
    wait_ready("mod.timeout");
    chk("mod.head", head, 2);
    chk("mod.count", count, 1);
`else
    chk("div.illegal", valid, 0);
    chk("div.ready", ready, 1);
`endif

    do_reset();
    for (int i = 1; i <= 4; i++) do_op(0, WIDTH'(i));
    chk("fill.full", full, 1);
    do_op(0, 8'd9);
    chk("ovf.valid", valid, 0);
    chk("ovf.head", head, 4);
    do_op(1, 8'd0); do_op(11, 8'd0);
    chk("frozen.count", count, 4);
    chk("frozen.head", head, 4);

    do_reset(); do_op(1, 8'd0); chk("popempty.valid", valid, 0);
    do_reset(); do_op(0, 8'd1); do_op(4, 8'd0); chk("add1.valid", valid, 0);
    chk("add1.head", head, 1);
    do_reset(); do_op(12, 8'd0); chk("op12.valid", valid, 0);
    do_reset(); do_op(0, 8'd7); do_op(0, 8'd0); do_op(7, 8'd0);
    chk("div0.valid", valid, 0);
    chk("div0.ready", ready, 1);
    chk("div0.count", count, 2);

    do_reset();
    do_op(0, 8'd6); do_op(0, 8'd2); do_op(7, 8'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.ready", ready, 1);
    chk("abort.count", count, 0);
    chk("abort.valid", valid, 1);

    do_reset();
    do_op(0, 8'd1); do_op(0, 8'd2); do_op(10, 8'd0);
    chk("swap.head", head, 1);
    do_op(9, 8'd0);
    chk("dup.count", count, 3);
    chk("dup.head", head, 1);
    do_op(11, 8'd0);
    chk("clear.empty", empty, 1);
    do_op(11, 8'd0);
    chk("clear2.valid", valid, 1);
    do_op(0, 8'd7); do_op(0, 8'd2);
    t_op = 4'd7; apply = 1'b1;
    @(posedge clk); #1;
    t_op = 4'd0; t_in = 8'h55;
    repeat (WIDTH) begin @(posedge clk); #1; end
    apply = 1'b0;
`ifdef STACK_CALC_DIV_EN
    chk("held.head", head, 3);
    chk("held.count", count, 1);
    chk("held.valid", valid, 1);
`else
    chk("held.valid", valid, 0);
    chk("held.count", count, 2);
`endif
    @(negedge clk);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
